// File: rtl/decoder_pkg.sv
// Shared types and constants for the hold-decoder slice.
// DECODER3TO8_ACTIVE_LOW_EN selects one-cold outputs with an all-ones idle value.
package decoder_pkg;

    localparam int DEFAULT_IN_W  = 3;
    localparam int DEFAULT_OUT_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Level every output line rests at when nothing is being driven.
`ifdef DECODER3TO8_ACTIVE_LOW_EN
    localparam logic IDLE_BIT = 1'b1;
`else
    localparam logic IDLE_BIT = 1'b0;
`endif

endpackage

// File: rtl/decoder3to8_hold_if.sv
// Code-in / line-out bundle of the hold decoder; master is the upstream side.
interface decoder3to8_hold_if #(
    parameter int IN_W  = decoder_pkg::DEFAULT_IN_W,
    parameter int OUT_W = decoder_pkg::DEFAULT_OUT_W
);
    logic [IN_W-1:0]  in_idx;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_onehot;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_idx, in_valid,
        input  in_ready, out_onehot, out_valid, busy
    );

    modport slave (
        input  in_idx, in_valid,
        output in_ready, out_onehot, out_valid, busy
    );
endinterface

// File: rtl/dec_onehot.sv
// Combinational index-to-line decoder; DECODER3TO8_ACTIVE_LOW_EN inverts to one-cold.
module dec_onehot #(
    parameter int IN_W  = decoder_pkg::DEFAULT_IN_W,
    parameter int OUT_W = decoder_pkg::DEFAULT_OUT_W
) (
    input  logic [IN_W-1:0]  i_idx,
    output logic [OUT_W-1:0] o_line
);
    logic [OUT_W-1:0] w_hot;

    assign w_hot = {{(OUT_W-1){1'b0}}, 1'b1} << i_idx;

`ifdef DECODER3TO8_ACTIVE_LOW_EN
    assign o_line = ~w_hot;
`else
    assign o_line = w_hot;
`endif
endmodule

// File: rtl/decoder3to8_hold.sv
// Streams index codes through an active register plus one pending slot and holds
// each decoded line for HOLD_CYCLES cycles (polarity via DECODER3TO8_ACTIVE_LOW_EN).
module decoder3to8_hold #(
    parameter int IN_W        = decoder_pkg::DEFAULT_IN_W,
    parameter int OUT_W       = decoder_pkg::DEFAULT_OUT_W,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input logic               clk,
    input logic               rst,
    decoder3to8_hold_if.slave bus
);
    import decoder_pkg::*;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [IN_W-1:0]  r_active_idx, w_active_idx_nxt;
    logic [IN_W-1:0]  r_pend_idx, w_pend_idx_nxt;
    logic             r_pend_valid, w_pend_valid_nxt;
    logic             w_ready;
    logic             w_accept;
    logic [OUT_W-1:0] w_decoded;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_active_idx <= '0;
            r_pend_idx   <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_active_idx <= w_active_idx_nxt;
            r_pend_idx   <= w_pend_idx_nxt;
            r_pend_valid <= w_pend_valid_nxt;
        end
    end

    // Ready depends only on registered state so upstream never sees a loop through in_valid.
    assign w_ready  = (r_state == ST_IDLE) || !r_pend_valid;
    assign w_accept = bus.in_valid && w_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_active_idx_nxt = r_active_idx;
        w_pend_idx_nxt   = r_pend_idx;
        w_pend_valid_nxt = r_pend_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt      = ST_DRIVE;
                    w_active_idx_nxt = bus.in_idx;
                    w_cnt_nxt        = RELOAD;
                end
            end
            ST_DRIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (w_accept) begin
                        w_pend_valid_nxt = 1'b1;
                        w_pend_idx_nxt   = bus.in_idx;
                    end
                end else if (r_pend_valid) begin
                    w_active_idx_nxt = r_pend_idx;
                    w_pend_valid_nxt = 1'b0;
                    w_cnt_nxt        = RELOAD;
                end else if (w_accept) begin
                    // Pending is empty, so a code arriving on the last hold cycle goes straight to active.
                    w_active_idx_nxt = bus.in_idx;
                    w_cnt_nxt        = RELOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    dec_onehot #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_dec (
        .i_idx  (r_active_idx),
        .o_line (w_decoded)
    );

    assign bus.in_ready   = w_ready;
    assign bus.out_valid  = (r_state == ST_DRIVE);
    assign bus.out_onehot = (r_state == ST_DRIVE) ? w_decoded : {OUT_W{IDLE_BIT}};
    assign bus.busy       = (r_state == ST_DRIVE) || r_pend_valid;
endmodule

// File: tb/tb_decoder3to8_hold.sv
// Self-checking bench for decoder3to8_hold: directed table, backpressure and
// HOLD_CYCLES=1 sequences, then randomized traffic against a queue-based model.
module tb_decoder3to8_hold;

    localparam int HOLD = 4;

    typedef struct {
        logic       r;
        logic       v;
        logic [2:0] idx;
        logic [7:0] line;
        logic       ov;
        logic       rdy;
        logic       bsy;
    } vec_t;

    logic clk = 1'b0;
    logic rst4;
    logic rst1;
    int   vectorCount = 0;
    int   missCount   = 0;
    vec_t tbl[$];

    logic [2:0] bpCodes[3]  = '{3'd1, 3'd3, 3'd6};
    logic [7:0] bpLine[14]  = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h08, 8'h08, 8'h08,
                                8'h08, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h00};
    logic       bpReady[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    decoder3to8_hold_if #(.IN_W(3), .OUT_W(8)) bus4 ();
    decoder3to8_hold_if #(.IN_W(3), .OUT_W(8)) bus1 ();

    decoder3to8_hold #(
        .IN_W(3), .OUT_W(8), .HOLD_CYCLES(HOLD), .CNT_W(8)
    ) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4.slave)
    );

    decoder3to8_hold #(
        .IN_W(3), .OUT_W(8), .HOLD_CYCLES(1), .CNT_W(8)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    // Expected values are written active-high; this maps them to the built polarity.
    function automatic logic [7:0] polar(input logic [7:0] x);
`ifdef DECODER3TO8_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    task automatic addVec(input logic r, input logic v, input logic [2:0] idx,
                          input logic [7:0] line, input logic ov, input logic rdy,
                          input logic bsy);
        vec_t e;
        e.r = r; e.v = v; e.idx = idx; e.line = line;
        e.ov = ov; e.rdy = rdy; e.bsy = bsy;
        tbl.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and return at the next falling edge.
    task automatic applyStimulus(input bit useOne, input logic r, input logic v,
                                 input logic [2:0] idx);
        if (useOne) begin
            rst1 = r; bus1.in_valid = v; bus1.in_idx = idx;
        end else begin
            rst4 = r; bus4.in_valid = v; bus4.in_idx = idx;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input bit useOne, input logic [7:0] expLine,
                               input logic expValid, input logic expReady, input logic expBusy);
        logic [7:0] aLine;
        logic       aV, aR, aB;
        logic [7:0] want;
        if (useOne) begin
            aLine = bus1.out_onehot; aV = bus1.out_valid; aR = bus1.in_ready; aB = bus1.busy;
        end else begin
            aLine = bus4.out_onehot; aV = bus4.out_valid; aR = bus4.in_ready; aB = bus4.busy;
        end
        want = polar(expLine);
        vectorCount++;
        if (aLine !== want || aV !== expValid || aR !== expReady || aB !== expBusy) begin
            missCount++;
            $display("[TB] FAIL %s @%0t: got onehot=%h valid=%b ready=%b busy=%b, want onehot=%h valid=%b ready=%b busy=%b",
                     name, $time, aLine, aV, aR, aB, want, expValid, expReady, expBusy);
        end
    endtask

    initial begin
        int q[$];
        int rem;
        int k;
        logic r, v, acc, rdyNow;
        logic [2:0] idx;
        logic [7:0] eLine;

        rst4 = 1'b1; bus4.in_valid = 1'b0; bus4.in_idx = '0;
        rst1 = 1'b1; bus1.in_valid = 1'b0; bus1.in_idx = '0;
        @(negedge clk);

        // Reset, single code 5, back-to-back 2 then 7, reset during the hold of 4 with 6 pending.
        addVec(1, 0, 0, 8'h00, 0, 1, 0);
        addVec(1, 0, 0, 8'h00, 0, 1, 0);
        addVec(0, 0, 0, 8'h00, 0, 1, 0);
        addVec(0, 1, 5, 8'h20, 1, 1, 1);
        for (int i = 0; i < 3; i++) addVec(0, 0, 0, 8'h20, 1, 1, 1);
        addVec(0, 0, 0, 8'h00, 0, 1, 0);
        addVec(0, 1, 2, 8'h04, 1, 1, 1);
        addVec(0, 1, 7, 8'h04, 1, 0, 1);
        addVec(0, 0, 0, 8'h04, 1, 0, 1);
        addVec(0, 0, 0, 8'h04, 1, 0, 1);
        for (int i = 0; i < 4; i++) addVec(0, 0, 0, 8'h80, 1, 1, 1);
        addVec(0, 0, 0, 8'h00, 0, 1, 0);
        addVec(0, 1, 4, 8'h10, 1, 1, 1);
        addVec(0, 1, 6, 8'h10, 1, 0, 1);
        addVec(1, 0, 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 6; i++) addVec(0, 0, 0, 8'h00, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(0, tbl[i].r, tbl[i].v, tbl[i].idx);
            checkOutput($sformatf("directed[%0d]", i), 0, tbl[i].line, tbl[i].ov,
                        tbl[i].rdy, tbl[i].bsy);
        end
        rst1 = 1'b0;

        // Backpressure: in_valid stays high and each code advances only on a handshake.
        k = 0;
        for (int i = 0; i < 14; i++) begin
            v = (k < 3);
            idx = v ? bpCodes[k] : 3'd0;
            rdyNow = bus4.in_ready;
            if (v && rdyNow) k++;
            applyStimulus(0, 0, v, idx);
            checkOutput($sformatf("backpressure[%0d]", i), 0, bpLine[i], (i < 12),
                        bpReady[i], (i < 12));
        end
        vectorCount++;
        if (k != 3) begin
            missCount++;
            $display("[TB] FAIL backpressure_accepts: got %0d codes accepted, want 3", k);
        end

        // HOLD_CYCLES=1 walks every index at full rate.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 1, 3'(i));
            eLine = 8'(1) << i;
            checkOutput($sformatf("hold1_walk[%0d]", i), 1, eLine, 1, 1, 1);
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("hold1_idle", 1, 8'h00, 0, 1, 0);

        // Randomized traffic: the block is a two-deep FIFO whose head plays for HOLD cycles.
        q.delete();
        rem = 0;
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 63) == 0);
            v   = ($urandom_range(0, 99) < 60);
            idx = 3'($urandom_range(0, 7));
            acc = !r && v && (q.size() < 2);
            applyStimulus(0, r, v, idx);
            if (r) begin
                q.delete();
            end else begin
                if (q.size() > 0) begin
                    rem--;
                    if (rem == 0) begin
                        void'(q.pop_front());
                        if (q.size() > 0) rem = HOLD;
                    end
                end
                if (acc) begin
                    q.push_back(int'(idx));
                    if (q.size() == 1) rem = HOLD;
                end
            end
            eLine = (q.size() > 0) ? (8'(1) << q[0]) : 8'h00;
            checkOutput($sformatf("random[%0d]", n), 0, eLine, (q.size() > 0),
                        (q.size() < 2), (q.size() > 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/decoder3to8_hold.md
Name: decoder3to8_hold

Overview:
- Sequential counterpart to the team's 8-to-3 priority encoder.
- Accepts a stream of 3-bit index codes over a valid/ready handshake and drives the matching one-hot 8-bit line for a fixed number of cycles.
- Has a one-entry pending buffer, so back-to-back codes play out without gaps.
- Sits downstream of an encoder or arbiter and drives select/enable lines, e.g. mux selects or per-channel strobes.

Parameters:
- IN_W, 3, width of index code.
- OUT_W, 8, width of one-hot output; must equal 2**IN_W.
- HOLD_CYCLES, 4, cycles each decoded one-hot stays asserted; legal range 1..255.
- CNT_W, 8, hold-counter width; must satisfy 2**CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_idx  input  IN_W  index code to decode.
- in_valid  input  1  in_idx is valid.
- in_ready  output  1  block can accept a code this cycle.
- out_onehot  output  OUT_W  decoded line; all-zero when idle.
- out_valid  output  1  out_onehot is currently driving a code.
- busy  output  1  active or pending code present.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_onehot=0, out_valid=0, busy=0, pending empty, counter=0, state=IDLE. in_ready=1 in the cycle after reset.
- Accept: a code is accepted when in_valid && in_ready at a clk edge. in_idx is sampled at that edge.
- in_ready is combinational from registered state only, never from in_valid:
  - IDLE: in_ready=1.
  - DRIVE: in_ready = !pend_valid.
- State IDLE:
  - On accept, the next cycle has out_onehot = 1<<in_idx, out_valid=1, cnt=HOLD_CYCLES-1, state DRIVE.
  - Latency from accept edge to output is 1 cycle.
- State DRIVE:
  - Output is held constant while cnt>0; cnt decrements each cycle.
  - An accept while cnt>0 writes the pending register.
- End of hold (cnt==0):
  - If pend_valid: load the pending code into active, reload cnt, clear pend_valid, stay in DRIVE. No idle gap.
  - Else, if an accept occurs this same cycle: bypass pending, load the new code directly, stay in DRIVE.
  - Else: go to IDLE. out_onehot=0 and out_valid=0 next cycle.
- Each code is asserted for exactly HOLD_CYCLES consecutive cycles.
- HOLD_CYCLES=1: cnt is always 0. One code is accepted and played per cycle at full throughput, and pending stays empty under continuous in_valid.
- Full: with active and pending both occupied, in_ready=0. in_valid held high is not lost; it is accepted when ready returns.
- busy = out_valid || pend_valid.
- Reset mid-operation: active and pending codes are discarded and all outputs return to reset values at that edge. No partial hold completes.
- Width rule: decode uses zero-extended shift; out_onehot has exactly one bit set whenever out_valid=1.

Optional Feature:
- Macro: DECODER3TO8_ACTIVE_LOW_EN.
- Defined:
  - out_onehot is one-cold: the selected bit is 0 and all others are 1.
  - Idle and reset value is all-ones, 8'hFF.
  - out_valid, in_ready and busy are unchanged.
- Undefined: active-high one-hot as described above; idle/reset value 0.

Decomposition:
- Shared package decoder_pkg holds:
  - state encoding constants ST_IDLE=0, ST_DRIVE=1;
  - default widths IN_W=3, OUT_W=8;
  - the idle output constant selected by the macro.
- Sub-module dec_onehot (purely combinational, IN_W to OUT_W, polarity from the macro) instantiated once on the active-code register.
- The FSM, counter and pending buffer stay in decoder3to8_hold.

Test Plan:
- Reset and idle: assert rst for 2 cycles, then release -> out_onehot=8'h00, out_valid=0, busy=0, in_ready=1.
- Single code: in_idx=5 with in_valid for 1 cycle, HOLD_CYCLES=4 -> next cycle out_onehot=8'b00100000 for exactly 4 cycles, then 8'h00 and out_valid=0.
- Back-to-back: idx 2 then idx 7 on consecutive cycles -> 8'h04 for 4 cycles immediately followed by 8'h80 for 4 cycles. in_ready=0 while pending is full; no gap between codes.
- Backpressure: in_valid held with idx 1, 3, 6 -> the third code waits until in_ready returns. Output sequence is 8'h02, 8'h08, 8'h40, each 4 cycles; no code lost or duplicated.
- HOLD_CYCLES=1: stream idx 0..7 one per cycle -> out_onehot walks 8'h01..8'h80 one per cycle, and in_ready stays 1.
- Reset mid-hold: rst in the 2nd hold cycle of idx 4 with idx 6 pending -> next cycle out_onehot=0 and busy=0. Idx 6 never appears. With DECODER3TO8_ACTIVE_LOW_EN defined, the idle value is 8'hFF and idx 4 gives 8'hEF.
